lsu_xbar: RTL and testbench

- Parametrised load/store front-end between the execute stage and two memory back-ends: the D-cache controller and the uncached device bus.
- Accepts one CPU request at a time over valid/ready. Decodes the region, aligns address, data and strobe to an XLEN-wide beat, and issues the access to the selected back-end.
- Extracts and extends load data, then returns a response with an error flag.
- Replaces the fixed-64-bit, DPI-based device path with a real handshaked device port.

---
 rtl/lsu_xbar.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_lsu_xbar.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_xbar.sv
`default_nettype none
// ============================================================================
// Module   : lsu_xbar
// Purpose  : Load/store front-end between the execute stage and two memory
//            back-ends (D-cache controller and uncached device bus). Accepts
//            one CPU request at a time, decodes the target region, aligns
//            address/data/strobes to an XLEN-wide beat, issues the access to
//            the selected back-end, then extracts and extends load data and
//            returns a response with an error flag.
//
// Ports    : clk, rst                 - clock, synchronous active-high reset
//            req_*                    - CPU request (valid/ready handshake)
//            resp_*                   - CPU response (valid/ready handshake)
//            mem_req_* / mem_resp_*   - D-cache controller request/response
//            dev_req_* / dev_resp_*   - device bus request/response
//
// Options  : LSU_MISALIGN_CHECK_EN - when defined, halfword/word/doubleword
//            accesses not aligned to their size are rejected with resp_err
//            and never reach a back-end. When undefined, such accesses are
//            issued and any bytes falling outside the beat are dropped.
//
// Revision : 1.0 - initial release
// ============================================================================
module lsu_xbar #(
    parameter int                XLEN     = 64,
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] DEV_BASE = 32'hA000_0000,
    parameter logic [ADDR_W-1:0] DEV_MASK = 32'hF000_0000
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [2:0]          req_funct3,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [XLEN-1:0]     req_wdata,

    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [XLEN-1:0]     resp_rdata,
    output logic                resp_err,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_req_we,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic [XLEN-1:0]     mem_req_wdata,
    output logic [XLEN/8-1:0]   mem_req_wstrb,
    input  logic                mem_resp_valid,
    output logic                mem_resp_ready,
    input  logic [XLEN-1:0]     mem_resp_rdata,
    input  logic                mem_resp_err,

    output logic                dev_req_valid,
    input  logic                dev_req_ready,
    output logic                dev_req_we,
    output logic [ADDR_W-1:0]   dev_req_addr,
    output logic [XLEN-1:0]     dev_req_wdata,
    output logic [XLEN/8-1:0]   dev_req_wstrb,
    input  logic                dev_resp_valid,
    output logic                dev_resp_ready,
    input  logic [XLEN-1:0]     dev_resp_rdata,
    input  logic                dev_resp_err
);

    localparam int                c_NB         = XLEN / 8;
    localparam int                c_OFFW       = $clog2(c_NB);
    localparam logic [ADDR_W-1:0] c_BEAT_MASK  = ~ADDR_W'(c_NB - 1);

    localparam logic [1:0]        c_ST_IDLE    = 2'd0;
    localparam logic [1:0]        c_ST_ISSUE   = 2'd1;
    localparam logic [1:0]        c_ST_WAIT    = 2'd2;
    localparam logic [1:0]        c_ST_RESP    = 2'd3;

    logic [1:0]          r_state;
    logic                r_we;
    logic [2:0]          r_funct3;
    logic [c_OFFW-1:0]   r_off;
    logic                r_dev;

    // ------------------------------------------------------------------
    // Request-side decode, evaluated on the incoming request in IDLE
    // ------------------------------------------------------------------
    logic [c_OFFW-1:0]   w_off;
    logic [1:0]          w_size;
    logic                w_is_dev;
    logic                w_illegal_f3;
    logic                w_misalign;
    logic                w_legal;
    logic [ADDR_W-1:0]   w_beat_addr;
    logic [c_NB-1:0]     w_strb_base;
    logic [c_NB-1:0]     w_wstrb;
    logic [XLEN-1:0]     w_wdata;

    assign w_off       = req_addr[c_OFFW-1:0];
    assign w_size      = req_funct3[1:0];
    assign w_is_dev    = (req_addr & DEV_MASK) == DEV_BASE;
    assign w_beat_addr = req_addr & c_BEAT_MASK;

    // Stores only have SB/SH/SW/SD (funct3[2]==0); loads have everything
    // except 111. A 32-bit datapath has no doubleword or LWU.
    always_comb begin
        w_illegal_f3 = 1'b0;
        if (req_we) begin
            w_illegal_f3 = req_funct3[2] | ((XLEN == 32) && (req_funct3 == 3'b011));
        end else begin
            w_illegal_f3 = (req_funct3 == 3'b111) |
                           ((XLEN == 32) && ((req_funct3 == 3'b011) || (req_funct3 == 3'b110)));
        end
    end

`ifdef LSU_MISALIGN_CHECK_EN
    logic [2:0] w_align_mask;
    always_comb begin
        w_align_mask = 3'b000;
        case (w_size)
            2'd1:    w_align_mask = 3'b001;
            2'd2:    w_align_mask = 3'b011;
            2'd3:    w_align_mask = 3'b111;
            default: w_align_mask = 3'b000;
        endcase
        w_misalign = |(req_addr[2:0] & w_align_mask);
    end
`else
    assign w_misalign = 1'b0;
`endif

    assign w_legal = ~w_illegal_f3 & ~w_misalign;

    // Base strobe has (1 << size) low bits set; shifting within c_NB bits
    // drops any lanes past the end of the beat.
    always_comb begin
        w_strb_base = '0;
        for (int i = 0; i < c_NB; i++) begin
            w_strb_base[i] = (i < (1 << w_size));
        end
    end

    assign w_wstrb = req_we ? (w_strb_base << w_off) : '0;
    assign w_wdata = req_we ? (req_wdata << {w_off, 3'b000}) : '0;

    // ------------------------------------------------------------------
    // Response-side selection and load extraction
    // ------------------------------------------------------------------
    logic              w_sel_req_ready;
    logic              w_sel_resp_valid;
    logic              w_sel_resp_err;
    logic [XLEN-1:0]   w_sel_resp_rdata;
    logic [XLEN-1:0]   w_shifted;
    logic [XLEN-1:0]   w_load_data;
    logic              w_msb;
    int                w_nbits;

    assign w_sel_req_ready  = r_dev ? dev_req_ready  : mem_req_ready;
    assign w_sel_resp_valid = r_dev ? dev_resp_valid : mem_resp_valid;
    assign w_sel_resp_err   = r_dev ? dev_resp_err   : mem_resp_err;
    assign w_sel_resp_rdata = r_dev ? dev_resp_rdata : mem_resp_rdata;
    assign w_shifted        = w_sel_resp_rdata >> {r_off, 3'b000};

    // Bits below the access width pass through; bits above take the access
    // MSB for signed loads (funct3[2]==0) and zero for unsigned loads.
    always_comb begin
        w_nbits     = 8 << r_funct3[1:0];
        w_msb       = 1'b0;
        w_load_data = '0;
        for (int i = 0; i < XLEN; i++) begin
            if (i == w_nbits - 1) begin
                w_msb = w_shifted[i];
            end
        end
        for (int i = 0; i < XLEN; i++) begin
            w_load_data[i] = (i < w_nbits) ? w_shifted[i] : (~r_funct3[2] & w_msb);
        end
    end

    // ------------------------------------------------------------------
    // Control FSM; every output is registered
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_ST_IDLE;
            r_we           <= 1'b0;
            r_funct3       <= 3'b000;
            r_off          <= '0;
            r_dev          <= 1'b0;
            req_ready      <= 1'b1;
            resp_valid     <= 1'b0;
            resp_rdata     <= '0;
            resp_err       <= 1'b0;
            mem_req_valid  <= 1'b0;
            mem_req_we     <= 1'b0;
            mem_req_addr   <= '0;
            mem_req_wdata  <= '0;
            mem_req_wstrb  <= '0;
            mem_resp_ready <= 1'b0;
            dev_req_valid  <= 1'b0;
            dev_req_we     <= 1'b0;
            dev_req_addr   <= '0;
            dev_req_wdata  <= '0;
            dev_req_wstrb  <= '0;
            dev_resp_ready <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        r_we      <= req_we;
                        r_funct3  <= req_funct3;
                        r_off     <= w_off;
                        r_dev     <= w_is_dev;
                        if (w_legal) begin
                            if (w_is_dev) begin
                                dev_req_valid <= 1'b1;
                                dev_req_we    <= req_we;
                                dev_req_addr  <= w_beat_addr;
                                dev_req_wdata <= w_wdata;
                                dev_req_wstrb <= w_wstrb;
                            end else begin
                                mem_req_valid <= 1'b1;
                                mem_req_we    <= req_we;
                                mem_req_addr  <= w_beat_addr;
                                mem_req_wdata <= w_wdata;
                                mem_req_wstrb <= w_wstrb;
                            end
                            r_state <= c_ST_ISSUE;
                        end else begin
                            // Rejected without touching either back-end.
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                            r_state    <= c_ST_RESP;
                        end
                    end
                end

                c_ST_ISSUE: begin
                    if (w_sel_req_ready) begin
                        mem_req_valid  <= 1'b0;
                        mem_req_we     <= 1'b0;
                        mem_req_addr   <= '0;
                        mem_req_wdata  <= '0;
                        mem_req_wstrb  <= '0;
                        dev_req_valid  <= 1'b0;
                        dev_req_we     <= 1'b0;
                        dev_req_addr   <= '0;
                        dev_req_wdata  <= '0;
                        dev_req_wstrb  <= '0;
                        mem_resp_ready <= ~r_dev;
                        dev_resp_ready <= r_dev;
                        r_state        <= c_ST_WAIT;
                    end
                end

                c_ST_WAIT: begin
                    if (w_sel_resp_valid) begin
                        mem_resp_ready <= 1'b0;
                        dev_resp_ready <= 1'b0;
                        resp_valid     <= 1'b1;
                        resp_err       <= w_sel_resp_err;
                        resp_rdata     <= (w_sel_resp_err | r_we) ? '0 : w_load_data;
                        r_state        <= c_ST_RESP;
                    end
                end

                c_ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        resp_rdata <= '0;
                        req_ready  <= 1'b1;
                        r_state    <= c_ST_IDLE;
                    end
                end

                default: begin
                    req_ready <= 1'b1;
                    r_state   <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_xbar.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_xbar
// Purpose  : Self-checking bench for lsu_xbar. Drives a 64-bit instance with
//            directed and random accesses, acting as both back-ends, and a
//            32-bit instance for width-specific legality. Expected values come
//            from a byte-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_xbar;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   total = 0;
    int   bad   = 0;

    // 64-bit instance signals
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [63:0] resp_rdata;
    logic        mem_req_valid, mem_req_ready, mem_req_we;
    logic [31:0] mem_req_addr;
    logic [63:0] mem_req_wdata;
    logic [7:0]  mem_req_wstrb;
    logic        mem_resp_valid, mem_resp_ready, mem_resp_err;
    logic [63:0] mem_resp_rdata;
    logic        dev_req_valid, dev_req_ready, dev_req_we;
    logic [31:0] dev_req_addr;
    logic [63:0] dev_req_wdata;
    logic [7:0]  dev_req_wstrb;
    logic        dev_resp_valid, dev_resp_ready, dev_resp_err;
    logic [63:0] dev_resp_rdata;

    // 32-bit instance signals
    logic        s_req_valid, s_req_ready, s_req_we;
    logic [2:0]  s_req_funct3;
    logic [31:0] s_req_addr;
    logic [31:0] s_req_wdata;
    logic        s_resp_valid, s_resp_ready, s_resp_err;
    logic [31:0] s_resp_rdata;
    logic        s_mem_req_valid, s_mem_req_ready, s_mem_req_we;
    logic [31:0] s_mem_req_addr;
    logic [31:0] s_mem_req_wdata;
    logic [3:0]  s_mem_req_wstrb;
    logic        s_mem_resp_valid, s_mem_resp_ready, s_mem_resp_err;
    logic [31:0] s_mem_resp_rdata;
    logic        s_dev_req_valid, s_dev_req_ready, s_dev_req_we;
    logic [31:0] s_dev_req_addr;
    logic [31:0] s_dev_req_wdata;
    logic [3:0]  s_dev_req_wstrb;
    logic        s_dev_resp_valid, s_dev_resp_ready, s_dev_resp_err;
    logic [31:0] s_dev_resp_rdata;

    lsu_xbar #(.XLEN(64)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
        .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
        .mem_resp_rdata(mem_resp_rdata), .mem_resp_err(mem_resp_err),
        .dev_req_valid(dev_req_valid), .dev_req_ready(dev_req_ready),
        .dev_req_we(dev_req_we), .dev_req_addr(dev_req_addr),
        .dev_req_wdata(dev_req_wdata), .dev_req_wstrb(dev_req_wstrb),
        .dev_resp_valid(dev_resp_valid), .dev_resp_ready(dev_resp_ready),
        .dev_resp_rdata(dev_resp_rdata), .dev_resp_err(dev_resp_err)
    );

    lsu_xbar #(.XLEN(32)) dut32 (
        .clk(clk), .rst(rst),
        .req_valid(s_req_valid), .req_ready(s_req_ready), .req_we(s_req_we),
        .req_funct3(s_req_funct3), .req_addr(s_req_addr), .req_wdata(s_req_wdata),
        .resp_valid(s_resp_valid), .resp_ready(s_resp_ready),
        .resp_rdata(s_resp_rdata), .resp_err(s_resp_err),
        .mem_req_valid(s_mem_req_valid), .mem_req_ready(s_mem_req_ready),
        .mem_req_we(s_mem_req_we), .mem_req_addr(s_mem_req_addr),
        .mem_req_wdata(s_mem_req_wdata), .mem_req_wstrb(s_mem_req_wstrb),
        .mem_resp_valid(s_mem_resp_valid), .mem_resp_ready(s_mem_resp_ready),
        .mem_resp_rdata(s_mem_resp_rdata), .mem_resp_err(s_mem_resp_err),
        .dev_req_valid(s_dev_req_valid), .dev_req_ready(s_dev_req_ready),
        .dev_req_we(s_dev_req_we), .dev_req_addr(s_dev_req_addr),
        .dev_req_wdata(s_dev_req_wdata), .dev_req_wstrb(s_dev_req_wstrb),
        .dev_resp_valid(s_dev_resp_valid), .dev_resp_ready(s_dev_resp_ready),
        .dev_resp_rdata(s_dev_resp_rdata), .dev_resp_err(s_dev_resp_err)
    );

    // Global time limit so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout obs=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Reference model (byte-level view of the access)
    // ------------------------------------------------------------------
    function automatic logic model_legal(input logic we, input logic [2:0] f3,
                                         input logic [31:0] a, input int xlen);
        logic ok;
        if (we) ok = (f3 <= 3'd3);
        else    ok = (f3 != 3'd7);
        if (xlen == 32 && f3 == 3'd3)         ok = 1'b0;
        if (xlen == 32 && !we && f3 == 3'd6)  ok = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
        if ((a % (32'd1 << f3[1:0])) != 0)    ok = 1'b0;
`else
        if (a == 32'hFFFF_FFFF)               ok = ok;  // address unused here
`endif
        return ok;
    endfunction

    function automatic logic [7:0] model_strb(input logic [2:0] f3, input logic [31:0] a,
                                              input int xlen);
        logic [7:0] s;
        int off, n;
        s   = 8'h00;
        off = int'(a % 32'(xlen / 8));
        n   = 1 << f3[1:0];
        for (int b = 0; b < xlen / 8; b++) s[b] = (b >= off) && (b < off + n);
        return s;
    endfunction

    function automatic logic [63:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [63:0] rd, input int xlen);
        logic [63:0] v;
        int off, n;
        v   = 64'd0;
        off = int'(a % 32'(xlen / 8));
        n   = 1 << f3[1:0];
        for (int b = 0; b < n; b++)
            if (off + b < xlen / 8) v[8*b +: 8] = rd[8*(off+b) +: 8];
        if (!f3[2] && (8 * n < xlen) && v[8*n-1])
            for (int i = 8 * n; i < xlen; i++) v[i] = 1'b1;
        return v;
    endfunction

    // ------------------------------------------------------------------
    // One full access on the 64-bit instance, with the bench acting as the
    // back-end: rdly cycles of request backpressure, pdly cycles before the
    // back-end responds, hold cycles of CPU response backpressure.
    // ------------------------------------------------------------------
    task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [63:0] wd, input logic [63:0] rd, input logic berr,
                          input int rdly, input int pdly, input int hold);
        logic        legal, dev, eerr;
        logic [31:0] eaddr;
        logic [7:0]  estrb;
        logic [63:0] ewd, erd;
        legal = model_legal(we, f3, a, 64);
        dev   = (a[31:28] == 4'hA);
        eaddr = a - (a % 32'd8);
        estrb = we ? model_strb(f3, a, 64) : 8'h00;
        ewd   = wd << (8 * (a % 32'd8));
        eerr  = !legal || berr;
        erd   = (eerr || we) ? 64'd0 : model_load(f3, a, rd, 64);

        chk("idle_req_ready", 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        step();
        req_valid = 1'b0;

        if (!legal) begin
            chk("illegal_mem_valid", 64'(mem_req_valid), 64'd0);
            chk("illegal_dev_valid", 64'(dev_req_valid), 64'd0);
        end else begin
            for (int k = 0; k <= rdly; k++) begin
                chk("sel_req_valid", 64'(dev ? dev_req_valid : mem_req_valid), 64'd1);
                chk("other_req_valid", 64'(dev ? mem_req_valid : dev_req_valid), 64'd0);
                chk("req_addr", 64'(dev ? dev_req_addr : mem_req_addr), 64'(eaddr));
                chk("req_wstrb", 64'(dev ? dev_req_wstrb : mem_req_wstrb), 64'(estrb));
                chk("req_we", 64'(dev ? dev_req_we : mem_req_we), 64'(we));
                if (we) chk("req_wdata", dev ? dev_req_wdata : mem_req_wdata, ewd);
                chk("busy_req_ready", 64'(req_ready), 64'd0);
                if (k == rdly) begin
                    if (dev) dev_req_ready = 1'b1;
                    else     mem_req_ready = 1'b1;
                end
                step();
            end
            mem_req_ready = 1'b0;
            dev_req_ready = 1'b0;
            chk("req_valid_drop", 64'(dev ? dev_req_valid : mem_req_valid), 64'd0);
            for (int k = 0; k <= pdly; k++) begin
                chk("sel_resp_ready", 64'(dev ? dev_resp_ready : mem_resp_ready), 64'd1);
                chk("early_resp_valid", 64'(resp_valid), 64'd0);
                if (k == pdly) begin
                    if (dev) begin
                        dev_resp_valid = 1'b1; dev_resp_rdata = rd; dev_resp_err = berr;
                    end else begin
                        mem_resp_valid = 1'b1; mem_resp_rdata = rd; mem_resp_err = berr;
                    end
                end
                step();
            end
            // Scramble back-end outputs so a missed capture shows up.
            mem_resp_valid = 1'b0; mem_resp_rdata = ~rd; mem_resp_err = ~berr;
            dev_resp_valid = 1'b0; dev_resp_rdata = ~rd; dev_resp_err = ~berr;
        end

        for (int k = 0; k <= hold; k++) begin
            chk("resp_valid", 64'(resp_valid), 64'd1);
            chk("resp_err", 64'(resp_err), 64'(eerr));
            chk("resp_rdata", resp_rdata, erd);
            chk("resp_req_ready", 64'(req_ready), 64'd0);
            chk("resp_no_mem_req", 64'(mem_req_valid), 64'd0);
            chk("resp_no_dev_req", 64'(dev_req_valid), 64'd0);
            if (k < hold) begin
                // A competing request while the response is held must be ignored.
                req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd0;
                req_addr = 32'h8000_0040; req_wdata = 64'd0;
            end else begin
                req_valid  = 1'b0;
                resp_ready = 1'b1;
            end
            step();
        end
        resp_ready = 1'b0;
        mem_resp_err = 1'b0; dev_resp_err = 1'b0;
        chk("resp_valid_drop", 64'(resp_valid), 64'd0);
    endtask

    // Access on the 32-bit instance with an always-ready memory back-end.
    task automatic access32(input logic we, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] rd);
        logic        legal;
        logic [63:0] erd;
        legal = model_legal(we, f3, a, 32);
        erd   = (!legal || we) ? 64'd0 : model_load(f3, a, 64'(rd), 32);
        s_req_valid = 1'b1; s_req_we = we; s_req_funct3 = f3; s_req_addr = a; s_req_wdata = wd;
        step();
        s_req_valid = 1'b0;
        if (!legal) begin
            chk("x32_no_mem_valid", 64'(s_mem_req_valid), 64'd0);
            chk("x32_no_dev_valid", 64'(s_dev_req_valid), 64'd0);
        end else begin
            chk("x32_mem_valid", 64'(s_mem_req_valid), 64'd1);
            chk("x32_addr", 64'(s_mem_req_addr), 64'(a - (a % 32'd4)));
            chk("x32_wstrb", 64'(s_mem_req_wstrb), we ? 64'(model_strb(f3, a, 32)) : 64'd0);
            s_mem_req_ready = 1'b1;
            step();
            s_mem_req_ready = 1'b0;
            s_mem_resp_valid = 1'b1; s_mem_resp_rdata = rd; s_mem_resp_err = 1'b0;
            step();
            s_mem_resp_valid = 1'b0;
        end
        chk("x32_resp_valid", 64'(s_resp_valid), 64'd1);
        chk("x32_resp_err", 64'(s_resp_err), 64'(!legal));
        chk("x32_resp_rdata", 64'(s_resp_rdata), erd);
        s_resp_ready = 1'b1;
        step();
        s_resp_ready = 1'b0;
        chk("x32_req_ready", 64'(s_req_ready), 64'd1);
    endtask

    initial begin
        logic        r_we;
        logic [2:0]  r_f3;
        logic [31:0] r_a;

        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 64'd0;
        resp_ready = 1'b0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = 64'd0; mem_resp_err = 1'b0;
        dev_req_ready = 1'b0; dev_resp_valid = 1'b0; dev_resp_rdata = 64'd0; dev_resp_err = 1'b0;
        s_req_valid = 1'b0; s_req_we = 1'b0; s_req_funct3 = 3'd0; s_req_addr = 32'd0; s_req_wdata = 32'd0;
        s_resp_ready = 1'b0;
        s_mem_req_ready = 1'b0; s_mem_resp_valid = 1'b0; s_mem_resp_rdata = 32'd0; s_mem_resp_err = 1'b0;
        s_dev_req_ready = 1'b0; s_dev_resp_valid = 1'b0; s_dev_resp_rdata = 32'd0; s_dev_resp_err = 1'b0;
        step();
        step();

        // Reset state
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_rdata", resp_rdata, 64'd0);
        chk("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
        chk("rst_dev_req_valid", 64'(dev_req_valid), 64'd0);
        chk("rst_mem_addr", 64'(mem_req_addr), 64'd0);
        chk("rst_mem_resp_ready", 64'(mem_resp_ready), 64'd0);
        rst = 1'b0;
        step();

        // LB sign-extended from byte lane 3
        access(1'b0, 3'd0, 32'h8000_0003, 64'd0, 64'h0000_0000_8000_0000, 1'b0, 0, 0, 0);
        // SH into the top halfword
        access(1'b1, 3'd1, 32'h8000_0006, 64'h1234, 64'd0, 1'b0, 0, 0, 0);
        // LW to the device region with 5 cycles of request backpressure
        access(1'b0, 3'd2, 32'hA000_0104, 64'd0, 64'h8765_4321_0000_0000, 1'b0, 5, 1, 0);
        // Device error on a load, response held for 3 cycles
        access(1'b0, 3'd3, 32'hA000_0008, 64'd0, 64'hDEAD_BEEF_CAFE_F00D, 1'b1, 0, 0, 3);
        // Illegal funct3: load 111, store 1xx
        access(1'b0, 3'd7, 32'h8000_0000, 64'd0, 64'd0, 1'b0, 0, 0, 1);
        access(1'b1, 3'd5, 32'h8000_0000, 64'hFF, 64'd0, 1'b0, 0, 0, 0);
        // Full-width LD and LWU
        access(1'b0, 3'd3, 32'h8000_0010, 64'd0, 64'hF123_4567_89AB_CDEF, 1'b0, 1, 2, 0);
        access(1'b0, 3'd6, 32'h8000_0014, 64'd0, 64'hF123_4567_89AB_CDEF, 1'b0, 0, 0, 0);

        // Reset while waiting for the back-end response
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h8000_0020;
        step();
        req_valid = 1'b0;
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        chk("wait_mem_resp_ready", 64'(mem_resp_ready), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_req_ready", 64'(req_ready), 64'd1);
        chk("midrst_mem_valid", 64'(mem_req_valid), 64'd0);
        chk("midrst_dev_valid", 64'(dev_req_valid), 64'd0);
        chk("midrst_resp_valid", 64'(resp_valid), 64'd0);
        chk("midrst_mem_resp_ready", 64'(mem_resp_ready), 64'd0);
        // LBU afterwards
        access(1'b0, 3'd4, 32'h8000_0001, 64'd0, 64'h0000_0000_0000_FF00, 1'b0, 0, 0, 0);

        // 32-bit instance: LD and SD rejected, misaligned LW, aligned signed LH
        access32(1'b0, 3'd3, 32'h8000_0000, 32'd0, 32'd0);
        access32(1'b1, 3'd3, 32'h8000_0000, 32'h55, 32'd0);
        access32(1'b0, 3'd2, 32'h8000_0002, 32'd0, 32'h8765_4321);
        access32(1'b0, 3'd1, 32'h8000_0006, 32'd0, 32'h8001_0000);
        access32(1'b1, 3'd0, 32'h8000_0003, 32'hA5, 32'd0);

        // Random accesses on the 64-bit instance
        for (int n = 0; n < 60; n++) begin
            r_we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) r_f3 = 3'($urandom_range(0, 7));
            else if (r_we)                 r_f3 = 3'($urandom_range(0, 3));
            else                           r_f3 = 3'($urandom_range(0, 6));
            r_a = ($urandom_range(0, 1) == 1 ? 32'hA000_0000 : 32'h8000_0000) |
                  32'($urandom_range(0, 4095));
            if ($urandom_range(0, 3) != 0) r_a = r_a - (r_a % (32'd1 << r_f3[1:0]));
            access(r_we, r_f3, r_a, {$urandom, $urandom}, {$urandom, $urandom},
                   ($urandom_range(0, 5) == 0), int'($urandom_range(0, 2)),
                   int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
